// File: rtl/alu_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_pkg
// Description : Shared shift-op encodings and pipeline sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  // Number of register stages: ceil(shamtW / stride).
  function automatic int calcStages(input int shamtW, input int stride);
    return (shamtW + stride - 1) / stride;
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_level.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_level
// Description : One combinational barrel-shifter level, shifting by DIST.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);
  import alu_shift_pkg::*;

  always_comb begin
    shifted = data;
    if (en) begin
      case (op)
        SH_SLL:  shifted = data << DIST;
        SH_SRL:  shifted = data >> DIST;
        // Sign comes from the original operand, carried down the pipe.
        SH_SRA:  shifted = {{DIST{sign}}, data[WIDTH-1:DIST]};
        default: shifted = {data[WIDTH-1-DIST:0], data[WIDTH-1:WIDTH-DIST]};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Multi-mode barrel shifter, STRIDE levels per stage, global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STRIDE  = 1,
  parameter int TAG_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  import alu_shift_pkg::*;

  localparam int NSTAGES = calcStages(SHAMT_W, STRIDE);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0) || (SHAMT_W != $clog2(WIDTH)) ||
      (STRIDE < 1) || (STRIDE > SHAMT_W)) begin : g_paramCheck
    $error("pipelined_barrel_shifter: illegal WIDTH/SHAMT_W/STRIDE combination");
  end

  logic [NSTAGES-1:0]              r_valid;
  logic [NSTAGES-1:0][WIDTH-1:0]   r_data;
  logic [NSTAGES-1:0][SHAMT_W-1:0] r_shamt;
  logic [NSTAGES-1:0][1:0]         r_op;
  logic [NSTAGES-1:0][TAG_W-1:0]   r_tag;
  logic [NSTAGES-1:0]              r_sign;

  logic [NSTAGES-1:0]              w_stgValid;
  logic [NSTAGES-1:0][WIDTH-1:0]   w_stgData;
  logic [NSTAGES-1:0][SHAMT_W-1:0] w_stgShamt;
  logic [NSTAGES-1:0][1:0]         w_stgOp;
  logic [NSTAGES-1:0][TAG_W-1:0]   w_stgTag;
  logic [NSTAGES-1:0]              w_stgSign;
  logic [NSTAGES-1:0][WIDTH-1:0]   w_stgOut;
  logic                            w_advance;
  logic                            w_unused;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int S = k / STRIDE;
    logic [WIDTH-1:0] w_lvlIn;
    logic [WIDTH-1:0] w_lvlOut;
    if ((k % STRIDE) == 0) begin : g_first
      assign w_lvlIn = w_stgData[S];
    end else begin : g_chain
      assign w_lvlIn = g_level[k-1].w_lvlOut;
    end
    barrel_shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .data    (w_lvlIn),
      .en      (w_stgShamt[S][k]),
      .op      (w_stgOp[S]),
      .sign    (w_stgSign[S]),
      .shifted (w_lvlOut)
    );
  end

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    localparam int LAST = (((s + 1) * STRIDE < SHAMT_W) ? (s + 1) * STRIDE : SHAMT_W) - 1;
    if (s == 0) begin : g_head
      assign w_stgValid[s] = in_valid;
      assign w_stgData[s]  = in_data;
      assign w_stgShamt[s] = in_shamt;
      assign w_stgOp[s]    = in_op;
      assign w_stgTag[s]   = in_tag;
      assign w_stgSign[s]  = in_data[WIDTH-1];
    end else begin : g_body
      assign w_stgValid[s] = r_valid[s-1];
      assign w_stgData[s]  = r_data[s-1];
      assign w_stgShamt[s] = r_shamt[s-1];
      assign w_stgOp[s]    = r_op[s-1];
      assign w_stgTag[s]   = r_tag[s-1];
      assign w_stgSign[s]  = r_sign[s-1];
    end
    assign w_stgOut[s] = g_level[LAST].w_lvlOut;
  end

  // The whole pipe moves as one; a held result freezes every stage behind it.
  assign w_advance = !r_valid[NSTAGES-1] | out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
      r_shamt <= '0;
      r_op    <= '0;
      r_tag   <= '0;
      r_sign  <= '0;
    end else if (w_advance) begin
      r_valid <= w_stgValid;
      r_data  <= w_stgOut;
      r_shamt <= w_stgShamt;
      r_op    <= w_stgOp;
      r_tag   <= w_stgTag;
      r_sign  <= w_stgSign;
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_valid[NSTAGES-1];
  assign out_data  = r_data[NSTAGES-1];
  assign out_tag   = r_tag[NSTAGES-1];
  assign busy      = |r_valid;

  // Already-consumed shamt bits and last-stage control are intentionally dropped.
  assign w_unused = ^{r_shamt, r_op[NSTAGES-1], r_sign[NSTAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Random + directed bench with a scoreboard and arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0, inReady, outValid, outReady = 1'b1, busy;
  logic [31:0] inData = '0, outData;
  logic [4:0]  inShamt = '0;
  logic [1:0]  inOp = '0;
  logic [3:0]  inTag = '0, outTag;

  logic        v16InValid = 1'b0, v16InReady, v16OutValid, v16Busy;
  logic        v16OutReady = 1'b1;
  logic [15:0] v16InData = '0, v16OutData;
  logic [3:0]  v16InShamt = '0;
  logic [1:0]  v16InOp = '0;
  logic [3:0]  v16InTag = '0, v16OutTag;

  int          nChecks = 0;
  int          nFails = 0;
  int          nEmitted = 0;
  logic [31:0] expData[$];
  logic [3:0]  expTag[$];
  logic [63:0] sbTmp;

  always #5 clock = ~clock;

  pipelined_barrel_shifter dut (
    .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_data(inData), .in_shamt(inShamt), .in_op(inOp), .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_tag(outTag), .busy(busy)
  );

  pipelined_barrel_shifter #(.WIDTH(16), .SHAMT_W(4), .STRIDE(2), .TAG_W(4)) dut16 (
    .clock(clock), .reset(reset), .in_valid(v16InValid), .in_ready(v16InReady),
    .in_data(v16InData), .in_shamt(v16InShamt), .in_op(v16InOp), .in_tag(v16InTag),
    .out_valid(v16OutValid), .out_ready(v16OutReady), .out_data(v16OutData),
    .out_tag(v16OutTag), .busy(v16Busy)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole shift in one step on a w-bit value held in 64 bits.
  function automatic logic [63:0] refShift(input logic [63:0] d, input int s,
                                            input logic [1:0] op, input int w);
    logic [63:0] mask;
    logic [63:0] dx;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    dx   = d & mask;
    case (op)
      2'b00:   r = (dx << s) & mask;
      2'b01:   r = dx >> s;
      2'b10:   r = ((dx[w-1] ? (dx | ~mask) : dx) >> s) & mask;
      default: r = (s == 0) ? dx : (((dx << s) | (dx >> (w - s))) & mask);
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every transfer on either side is observed mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      expData.delete();
      expTag.delete();
    end else begin
      if (outValid && outReady) begin
        nEmitted++;
        checkVal("sb_expected_present", (expData.size() != 0), 1);
        if (expData.size() != 0) begin
          checkVal("sb_data", outData, expData.pop_front());
          checkVal("sb_tag", outTag, expTag.pop_front());
        end
      end
      if (inValid && inReady) begin
        sbTmp = refShift({32'd0, inData}, int'(inShamt), inOp, 32);
        expData.push_back(sbTmp[31:0]);
        expTag.push_back(inTag);
      end
    end
  end

  task automatic singleOp(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic [31:0] exp);
    int lat;
    logic [3:0] t;
    t = inTag + 4'd1;
    inValid = 1'b1; inData = d; inShamt = s; inOp = op; inTag = t;
    #1;
    checkVal({name, "_ready"}, inReady, 1);
    tick();
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 20) begin
      tick();
      lat++;
    end
    checkVal({name, "_latency"}, lat, 5);
    checkVal({name, "_data"}, outData, exp);
    checkVal({name, "_tag"}, outTag, t);
    tick();
  endtask

  task automatic singleOp16(input string name, input logic [15:0] d, input logic [3:0] s,
                            input logic [1:0] op, input logic [15:0] exp);
    int lat;
    v16InValid = 1'b1; v16InData = d; v16InShamt = s; v16InOp = op; v16InTag = 4'hA;
    #1;
    checkVal({name, "_ready"}, v16InReady, 1);
    tick();
    v16InValid = 1'b0;
    lat = 1;
    while (!v16OutValid && lat < 20) begin
      tick();
      lat++;
    end
    checkVal({name, "_latency"}, lat, 2);
    checkVal({name, "_data"}, v16OutData, exp);
    checkVal({name, "_tag"}, v16OutTag, 4'hA);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] holdData;
    logic [3:0]  holdTag;
    int          emitBase, issued, cyc, w;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkVal("rst_out_valid", outValid, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_out_data", outData, 0);
    checkVal("rst_out_tag", outTag, 0);
    checkVal("rst_in_ready", inReady, 1);
    checkVal("rst16_out_valid", v16OutValid, 0);

    singleOp("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    singleOp("sra4",  32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    singleOp("srl4",  32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    singleOp("rol1",  32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003);
    for (int op = 0; op < 4; op++)
      singleOp("zero_shamt", 32'hDEAD_BEEF, 5'd0, op[1:0], 32'hDEAD_BEEF);

    // Back-to-back with no bubbles.
    fork
      begin : b2bIssue
        for (int i = 0; i < 8; i++) begin
          inValid = 1'b1; inData = $urandom; inShamt = 5'($urandom); inOp = 2'($urandom);
          inTag = i[3:0];
          tick();
        end
        inValid = 1'b0;
      end
      begin : b2bCollect
        int wt;
        wt = 0;
        while (!outValid && wt < 20) begin
          tick();
          wt++;
        end
        for (int i = 0; i < 8; i++) begin
          checkVal("b2b_valid", outValid, 1);
          checkVal("b2b_tag", outTag, i[3:0]);
          tick();
        end
      end
    join
    tick();

    // Backpressure with a full pipe.
    emitBase = nEmitted;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inData = $urandom; inShamt = 5'($urandom); inOp = 2'($urandom);
      inTag = 4'(8 + i);
      tick();
    end
    inData = 32'h1234_5678; inShamt = 5'd7; inOp = 2'b11; inTag = 4'd13;
    outReady = 1'b0;
    #1;
    checkVal("bp_head_valid", outValid, 1);
    checkVal("bp_head_tag", outTag, 8);
    holdData = outData;
    holdTag  = outTag;
    for (int c = 0; c < 3; c++) begin
      checkVal("bp_in_ready", inReady, 0);
      checkVal("bp_busy", busy, 1);
      tick();
      checkVal("bp_data_stable", outData, holdData);
      checkVal("bp_tag_stable", outTag, holdTag);
    end
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    checkVal("bp_drained_busy", busy, 0);
    checkVal("bp_emitted", nEmitted - emitBase, 6);
    checkVal("bp_queue_empty", expData.size(), 0);

    // Random valid/ready traffic.
    issued = 0;
    cyc = 0;
    while (issued < 1000 && cyc < 20000) begin
      inValid  = ($urandom_range(0, 3) != 0);
      inData   = $urandom;
      inShamt  = 5'($urandom);
      inOp     = 2'($urandom);
      inTag    = issued[3:0];
      outReady = ($urandom_range(0, 3) != 0);
      #1;
      if (inValid && inReady) issued++;
      tick();
      cyc++;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checkVal("rand_issued", issued, 1000);
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    checkVal("rand_drain_busy", busy, 0);
    checkVal("rand_queue_empty", expData.size(), 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = $urandom; inShamt = 5'($urandom); inOp = 2'($urandom);
      inTag = i[3:0];
      tick();
    end
    inValid = 1'b0;
    checkVal("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    checkVal("mid_rst_out_valid", outValid, 0);
    checkVal("mid_rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    checkVal("mid_in_ready", inReady, 1);
    for (int c = 0; c < 8; c++) begin
      checkVal("mid_no_stale", outValid, 0);
      tick();
    end

    // Narrow configuration.
    singleOp16("w16_sra15", 16'h8001, 4'd15, 2'b10, 16'hFFFF);
    singleOp16("w16_rol15", 16'h8001, 4'd15, 2'b11, 16'hC000);
    singleOp16("w16_srl3",  16'hF0F0, 4'd3,  2'b01, 16'h1E1E);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined, multi-mode barrel shifter for the ALU/datapath.
- Supports logical left, logical right, arithmetic right and rotate left shifts, with width and pipeline depth set by parameters.
- Valid/ready handshake on input and output, with whole-pipeline stall on backpressure.
- A sideband tag travels with each operation so the issuing logic can match results to requests.

Parameters:
- WIDTH, 32: data width; must be a power of two, at least 2.
- SHAMT_W, 5: shift-amount width; must equal log2(WIDTH). An elaboration check fails otherwise.
- STRIDE, 1: number of mux levels per pipeline register. Must be 1..SHAMT_W.
- TAG_W, 4: sideband tag width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  pipeline can accept an operation this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, unsigned, 0..WIDTH-1
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- in_tag  in  TAG_W  sideband tag, passed through unmodified
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  at least one pipeline stage holds a valid operation

Behaviour:
- Levels and stages:
  - Level k (k = 0..SHAMT_W-1) shifts by 2^k when shamt[k] = 1; otherwise it passes data through.
  - Levels are applied in ascending k.
  - A pipeline register follows every STRIDE levels, plus always one after the final level.
  - NSTAGES = ceil(SHAMT_W / STRIDE). With defaults, NSTAGES = 5.
- Per-stage state: valid bit, partial data, remaining shamt bits, op, tag. Op and tag travel unchanged.
- Fill rules per mode at each level:
  - SLL: vacated LSBs fill with 0.
  - SRL: vacated MSBs fill with 0.
  - SRA: vacated MSBs fill with the operand MSB. The sign bit is captured at stage 0 and carried down the pipe.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- shamt = 0 gives out_data = in_data for all modes.
- Advance signal: advance = !out_valid | out_ready.
  - All stages shift forward together when advance = 1; all hold when advance = 0.
- in_ready = advance, combinational from out_ready and the last stage's valid bit.
- An operation is accepted when in_valid & in_ready. Bubbles (valid = 0) propagate when in_valid = 0.
- Latency is NSTAGES cycles from acceptance to out_valid while out_ready stays high.
- Throughput is one operation per cycle with no bubbles when out_ready is held high.
- Results emerge in acceptance order. No operation is dropped or duplicated under any out_ready pattern.
- Outputs are registered from the last stage. out_data and out_tag stay stable while out_valid = 1 and out_ready = 0.
- Reset:
  - All stage valid bits clear; out_valid = 0, busy = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation: all in-flight operations are discarded. No out_valid is produced for them.
- Simultaneous accept and emit, with a full pipe and out_ready = 1: both occur in the same cycle.
- busy = OR of all stage valid bits.

Decomposition:
- Shared package (alu_shift_pkg):
  - op encodings: SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROL = 2'b11
  - a function computing NSTAGES from SHAMT_W and STRIDE
- Sub-module barrel_shift_level, parametrised by WIDTH and DIST:
  - purely combinational, one level
  - inputs: data, enable bit, op, sign
  - output: shifted data
- The top instantiates SHAMT_W levels via generate and inserts stage registers per STRIDE.

Test Plan:
- Single operations with defaults, out_ready held at 1:
  - SLL 0x00000001 by 31 -> 0x80000000, out_valid exactly 5 cycles after acceptance.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - ROL 0x80000001 by 1 -> 0x00000003.
  - Any op with shamt 0 on 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back: 8 consecutive operations with tags 0..7, out_ready = 1 -> 8 consecutive out_valid cycles, tags 0..7 in order, no bubbles.
- Backpressure:
  - Pipe full; hold out_ready = 0 for 3 cycles.
  - During the hold: in_ready = 0 and out_data/out_tag stable.
  - After release: remaining results emerge in order with none lost.
- Random in_valid/out_ready toggling, 1000 operations, compared against a reference model -> all results match, order preserved.
- Reset mid-operation: assert reset with 3 operations in flight -> out_valid = 0 and busy = 0 next cycle; no stale results after reset deasserts.
- Configuration WIDTH = 16, SHAMT_W = 4, STRIDE = 2:
  - Latency is 2 cycles.
  - SRA 0x8001 by 15 -> 0xFFFF.
  - ROL 0x8001 by 15 -> 0xC000.
